// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC slave-side write arbiters.
package noc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam int NUM_M_DEFAULT = 4;

  // Per-slave master access masks: only S1, S5 and S6 are reachable from master 3.
  localparam logic [3:0] S0_ACCESS_MASK = 4'b0111;
  localparam logic [3:0] S1_ACCESS_MASK = 4'b1111;
  localparam logic [3:0] S2_ACCESS_MASK = 4'b0111;
  localparam logic [3:0] S3_ACCESS_MASK = 4'b0111;
  localparam logic [3:0] S4_ACCESS_MASK = 4'b0111;
  localparam logic [3:0] S5_ACCESS_MASK = 4'b1111;
  localparam logic [3:0] S6_ACCESS_MASK = 4'b1111;
  localparam logic [3:0] S7_ACCESS_MASK = 4'b0111;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] cand_s;
  logic          found_s;

  // Rotating priority search starting one past the previous winner
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int off = 1; off <= N; off++) begin
      cand_s = IW'((int'(last) + off) % N);
      if (!found_s && req[cand_s]) begin
        found_s         = 1'b1;
        gnt_oh[cand_s]  = 1'b1;
        gnt_idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/axi_slv_wr_arbiter.sv
// AXI write-channel arbiter in front of one slave: IDLE -> ADDR -> DATA per burst.
// Define AXI_SLV_WR_ARB_QOS_EN to pick the highest-AWQOS eligible master first.
module axi_slv_wr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int               NUM_M       = NUM_M_DEFAULT,
  parameter logic [NUM_M-1:0] ACCESS_MASK = 4'b1111
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M-1:0]           m_awvalid,
  input  logic [4*NUM_M-1:0]         m_awqos,
  output logic [NUM_M-1:0]           m_awready,
  output logic                       s_awvalid,
  input  logic                       s_awready,
  input  logic                       s_wvalid,
  input  logic                       s_wready,
  input  logic                       s_wlast,
  output logic [$clog2(NUM_M)-1:0]   grant_idx,
  output logic                       w_route_en,
  output logic [NUM_M-1:0]           access_err,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_M);

  arb_state_e       state_r;
  arb_state_e       state_nx_s;
  logic [IW-1:0]    last_grant_r;
  logic [NUM_M-1:0] access_err_r;
  logic [NUM_M-1:0] elig_s;
  logic [NUM_M-1:0] cand_req_s;
  logic [NUM_M-1:0] pick_oh_unused_s;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_any_s;
  logic             w_done_s;

  assign elig_s   = m_awvalid & ACCESS_MASK;
  assign w_done_s = s_wvalid & s_wready & s_wlast;

`ifdef AXI_SLV_WR_ARB_QOS_EN
  logic [3:0] qos_max_s;

  // Keep only eligible masters at the highest QoS; round-robin breaks the tie
  always_comb begin
    qos_max_s  = 4'd0;
    cand_req_s = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (elig_s[i] && (m_awqos[4*i +: 4] > qos_max_s)) begin
        qos_max_s = m_awqos[4*i +: 4];
      end else begin
        qos_max_s = qos_max_s;
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      cand_req_s[i] = elig_s[i] && (m_awqos[4*i +: 4] == qos_max_s);
    end
  end
`else
  logic qos_unused_s;

  assign qos_unused_s = ^m_awqos;
  assign cand_req_s   = elig_s;
`endif

  rr_pick #(
    .N  (NUM_M),
    .IW (IW)
  ) u_rr_pick (
    .req     (cand_req_s),
    .last    (last_grant_r),
    .gnt_oh  (pick_oh_unused_s),
    .gnt_idx (pick_idx_s),
    .any     (pick_any_s)
  );

  // State, grant pointers and registered access errors
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      grant_idx    <= '0;
      last_grant_r <= IW'(NUM_M - 1);
      access_err_r <= '0;
    end else begin
      state_r      <= state_nx_s;
      access_err_r <= m_awvalid & ~ACCESS_MASK;
      if (state_r == ST_IDLE && pick_any_s) begin
        grant_idx <= pick_idx_s;
      end else begin
        grant_idx <= grant_idx;
      end
      if (state_r == ST_DATA && w_done_s) begin
        last_grant_r <= grant_idx;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // Next-state: grant is held through ADDR regardless of the master's awvalid
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) state_nx_s = ST_ADDR;
        else            state_nx_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (s_awready) state_nx_s = ST_DATA;
        else           state_nx_s = ST_ADDR;
      end
      ST_DATA: begin
        if (w_done_s) state_nx_s = ST_IDLE;
        else          state_nx_s = ST_DATA;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; forced low while rst is asserted
  always_comb begin
    m_awready  = '0;
    s_awvalid  = 1'b0;
    w_route_en = 1'b0;
    busy       = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: busy = 1'b0;
        ST_ADDR: begin
          s_awvalid            = 1'b1;
          busy                 = 1'b1;
          m_awready[grant_idx] = s_awready;
        end
        ST_DATA: begin
          w_route_en = 1'b1;
          busy       = 1'b1;
        end
        default: busy = 1'b0;
      endcase
    end
  end

  assign access_err = access_err_r & {NUM_M{~rst}};

endmodule

// File: tb/tb_axi_slv_wr_arbiter.sv
// Directed scoreboard bench: expected grants are queued with the stimulus and popped at each AW handshake.
module tb_axi_slv_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  m_awvalid;
  logic [15:0] m_awqos;
  logic [3:0]  m_awready;
  logic        s_awvalid;
  logic        s_awready;
  logic        s_wvalid;
  logic        s_wready;
  logic        s_wlast;
  logic [1:0]  grant_idx;
  logic        w_route_en;
  logic [3:0]  access_err;
  logic        busy;

  logic [3:0]  m_awvalid_b;
  logic [3:0]  m_awready_b;
  logic        s_awvalid_b;
  logic [1:0]  grant_idx_b;
  logic        w_route_en_b;
  logic [3:0]  access_err_b;
  logic        busy_b;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];
  int lat;

  always #5 clk = ~clk;

  axi_slv_wr_arbiter #(.NUM_M(4), .ACCESS_MASK(4'b1111)) dut (
    .clk(clk), .rst(rst), .m_awvalid(m_awvalid), .m_awqos(m_awqos),
    .m_awready(m_awready), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .grant_idx(grant_idx), .w_route_en(w_route_en), .access_err(access_err), .busy(busy)
  );

  axi_slv_wr_arbiter #(.NUM_M(4), .ACCESS_MASK(4'b0111)) dut_b (
    .clk(clk), .rst(rst), .m_awvalid(m_awvalid_b), .m_awqos(m_awqos),
    .m_awready(m_awready_b), .s_awvalid(s_awvalid_b), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .grant_idx(grant_idx_b), .w_route_en(w_route_en_b), .access_err(access_err_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m_awvalid = 4'd0; m_awvalid_b = 4'd0;
    s_awready = 1'b0; s_wvalid = 1'b0; s_wready = 1'b0; s_wlast = 1'b0;
    #1;
    chk("rst_outputs", {m_awready, s_awvalid, w_route_en, access_err, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_grant_idx", grant_idx, 32'd0);
    chk("rst_busy", busy, 32'd0);
  endtask

  // One full burst: wait for AW, check grant, optional AW stall with early W, then W beats.
  task automatic burst(input int beats, input int aw_delay, input logic [3:0] keep, output int latency);
    int g;
    latency = 0;
    #1;
    while (s_awvalid !== 1'b1 && latency < 20) begin
      @(negedge clk); #1;
      latency++;
    end
    chk("aw_valid", s_awvalid, 32'd1);
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed grant %0d expected none", grant_idx);
      g = 0;
    end else begin
      g = exp_q.pop_front();
      chk("grant_idx", grant_idx, 32'(g));
    end
    for (int d = 0; d < aw_delay; d++) begin
      s_wvalid = 1'b1; s_wready = 1'b1; s_wlast = 1'b1;
      #1;
      chk("aw_stall_ready", m_awready, 32'd0);
      chk("aw_stall_wroute", w_route_en, 32'd0);
      @(negedge clk); #1;
    end
    chk("aw_still_valid", s_awvalid, 32'd1);
    s_wvalid = 1'b0; s_wready = 1'b0; s_wlast = 1'b0; s_awready = 1'b1;
    #1;
    chk("aw_ready_onehot", m_awready, 32'(4'b0001 << g));
    @(negedge clk);
    s_awready = 1'b0;
    m_awvalid[g] = keep[g];
    for (int b = 0; b < beats; b++) begin
      s_wvalid = 1'b1; s_wready = 1'b1; s_wlast = (b == beats - 1);
      #1;
      chk("w_route_en", w_route_en, 32'd1);
      chk("data_busy", busy, 32'd1);
      @(negedge clk);
    end
    s_wvalid = 1'b0; s_wready = 1'b0; s_wlast = 1'b0;
    #1;
    chk("idle_busy", busy, 32'd0);
    chk("idle_awvalid", s_awvalid, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; m_awvalid = 4'd0; m_awvalid_b = 4'd0; m_awqos = 16'd0;
    s_awready = 1'b0; s_wvalid = 1'b0; s_wready = 1'b0; s_wlast = 1'b0;

    // M0 and M2 together: M0 first, then M2 after exactly one IDLE cycle
    do_reset();
    m_awvalid = 4'b0101;
    exp_q.push_back(0); exp_q.push_back(2);
    burst(2, 1, 4'b0100, lat);
    chk("latency_first", 32'(lat), 32'd1);
    burst(3, 0, 4'b0000, lat);
    chk("latency_b2b", 32'(lat), 32'd1);

    // All four continuously with single-beat bursts
    do_reset();
    m_awvalid = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      burst(1, 0, 4'b1111, lat);
      chk("rr_latency", 32'(lat), 32'd1);
    end
    m_awvalid = 4'd0;
    @(negedge clk); #1;
    chk("rr_drained_busy", busy, 32'd0);

    // Denied master 3 on a slave that excludes it
    do_reset();
    m_awvalid_b = 4'b1000;
    #1;
    chk("deny_err_same_cycle", access_err_b, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("deny_err", access_err_b, 32'h8);
      chk("deny_ready", m_awready_b, 32'd0);
      chk("deny_busy", busy_b, 32'd0);
      chk("deny_awvalid", {s_awvalid_b, w_route_en_b, grant_idx_b}, 32'd0);
    end
    m_awvalid_b = 4'd0;
    @(negedge clk); #1;
    chk("deny_err_clear", access_err_b, 32'd0);

    // M1 qos 2 vs M2 qos 9
    do_reset();
    m_awqos = {4'd0, 4'd9, 4'd2, 4'd0};
    m_awvalid = 4'b0110;
`ifdef AXI_SLV_WR_ARB_QOS_EN
    exp_q.push_back(2); exp_q.push_back(1);
`else
    exp_q.push_back(1); exp_q.push_back(2);
`endif
    burst(1, 0, 4'b0000, lat);
    burst(1, 0, 4'b0000, lat);

    // Equal QoS falls back to round-robin order
    do_reset();
    m_awqos = {4'd0, 4'd5, 4'd5, 4'd0};
    m_awvalid = 4'b0110;
    exp_q.push_back(1); exp_q.push_back(2);
    burst(1, 0, 4'b0000, lat);
    burst(1, 0, 4'b0000, lat);

    // Reset in the middle of a 4-beat burst with a 3-cycle AW stall
    do_reset();
    m_awqos = 16'd0;
    m_awvalid = 4'b0001;
    exp_q.push_back(0);
    burst(1, 0, 4'b0000, lat);
    m_awvalid = 4'b0010;
    lat = 0;
    #1;
    while (s_awvalid !== 1'b1 && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    chk("abort_aw_valid", s_awvalid, 32'd1);
    chk("abort_grant", grant_idx, 32'd1);
    for (int d = 0; d < 3; d++) begin
      chk("abort_stall_ready", m_awready, 32'd0);
      @(negedge clk); #1;
    end
    s_awready = 1'b1;
    #1;
    chk("abort_aw_ready", m_awready, 32'h2);
    @(negedge clk);
    s_awready = 1'b0; m_awvalid = 4'd0;
    s_wvalid = 1'b1; s_wready = 1'b1; s_wlast = 1'b0;
    #1;
    chk("abort_beat1_route", w_route_en, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rst_outputs", {m_awready, s_awvalid, w_route_en, access_err, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0; s_wvalid = 1'b0; s_wready = 1'b0; s_wlast = 1'b0;
    #1;
    chk("abort_idle_busy", busy, 32'd0);
    chk("abort_idle_awvalid", s_awvalid, 32'd0);
    chk("abort_grant_reset", grant_idx, 32'd0);
    m_awvalid = 4'b0011;
    exp_q.push_back(0); exp_q.push_back(1);
    burst(1, 0, 4'b0000, lat);
    burst(1, 0, 4'b0000, lat);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
